// File: rtl/clk_mgr_a_pkg.sv
// Shared constants and elaboration-time helpers for the clk_mgr_a clock-enable generator.
package clk_mgr_a_pkg;

  localparam longint unsigned DEF_INPUT_CLOCK_FREQ = 64'd100_000_000;
  localparam longint unsigned DEF_SYSCLK_FREQ      = 64'd80_000_000;
  localparam longint unsigned DEF_CLKOUT1_FREQ     = 64'd50_000_000;
  localparam longint unsigned DEF_CLKOUT2_FREQ     = 64'd25_000_000;
  localparam longint unsigned DEF_CLKOUT3_FREQ     = 64'd150_000_000;
  localparam longint unsigned DEF_CLKOUT4_FREQ     = 64'd200_000_000;
  localparam int unsigned     DEF_LOCK_CYCLES      = 16;
  localparam int unsigned     DEF_ACC_W            = 32;

  // Channel order inside the strobe vectors: SYS first, then user channels 1-4.
  localparam int unsigned NUM_CH = 5;

  // round(freq * 2^acc_w / fin); wide intermediate so large ratios cannot overflow.
  function automatic logic [63:0] calc_inc(input longint unsigned freq,
                                           input longint unsigned fin,
                                           input int unsigned     acc_w);
    logic [127:0] num;
    logic [127:0] quo;
    if (fin == 0) begin
      quo = '0;
    end else begin
      num = (128'(freq) << acc_w) + 128'(fin >> 1);
      quo = num / 128'(fin);
    end
    return quo[63:0];
  endfunction

  function automatic bit calc_sat(input longint unsigned freq,
                                  input longint unsigned fin);
    return freq >= fin;
  endfunction

  // Square-wave accumulator step: twice the strobe step, clamped below 2^acc_w.
  function automatic logic [63:0] calc_sq_step(input logic [63:0] inc,
                                               input int unsigned acc_w);
    logic [64:0] dbl;
    logic [64:0] lim;
    dbl = {inc, 1'b0};
    lim = (65'd1 << acc_w) - 65'd1;
    return (dbl > lim) ? lim[63:0] : dbl[63:0];
  endfunction

endpackage

// File: rtl/clk_mgr_a_nco.sv
// One phase-accumulator channel: carry-driven enable strobe, saturation override and,
// with CLKMGR_SQUARE_OUT_EN defined, a toggle-flop square output on a second accumulator.
module clk_mgr_a_nco
  import clk_mgr_a_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter logic [63:0] INC   = '0,
  parameter bit          SAT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic strobe
`ifdef CLKMGR_SQUARE_OUT_EN
  ,
  output logic sq
`endif
);

  localparam logic [ACC_W-1:0] STEP = INC[ACC_W-1:0];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             strobe_q, strobe_d;
  logic [ACC_W:0]   sum;

  // A saturated channel ignores its accumulator, so it is parked at zero.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, STEP};
    acc_d    = '0;
    strobe_d = 1'b0;
    if (run) begin
      acc_d    = SAT ? '0 : sum[ACC_W-1:0];
      strobe_d = SAT | sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

`ifdef CLKMGR_SQUARE_OUT_EN
  localparam logic [63:0]      SQ_STEP64 = calc_sq_step(INC, ACC_W);
  localparam logic [ACC_W-1:0] SQ_STEP   = SQ_STEP64[ACC_W-1:0];

  logic [ACC_W-1:0] sq_acc_q, sq_acc_d;
  logic             tgl_q, tgl_d;
  logic [ACC_W:0]   sq_sum;

  // Each carry of the double-rate accumulator is one half period of the square wave.
  always_comb begin
    sq_sum   = {1'b0, sq_acc_q} + {1'b0, SQ_STEP};
    sq_acc_d = '0;
    tgl_d    = 1'b0;
    if (run) begin
      sq_acc_d = sq_sum[ACC_W-1:0];
      tgl_d    = tgl_q ^ sq_sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_acc_q <= '0;
      tgl_q    <= 1'b0;
    end else begin
      sq_acc_q <= sq_acc_d;
      tgl_q    <= tgl_d;
    end
  end

  assign sq = tgl_q;
`endif

endmodule

// File: rtl/clk_mgr_a.sv
// Clock manager top: lock counter plus five NCO channels producing OSC_IN-rate enable strobes.
// Define CLKMGR_SQUARE_OUT_EN to add the *_SQ near-50% square outputs.
module clk_mgr_a
  import clk_mgr_a_pkg::*;
#(
  parameter longint unsigned INPUT_CLOCK_FREQ = DEF_INPUT_CLOCK_FREQ,
  parameter longint unsigned SYSCLK_FREQ      = DEF_SYSCLK_FREQ,
  parameter longint unsigned CLKOUT1_FREQ     = DEF_CLKOUT1_FREQ,
  parameter longint unsigned CLKOUT2_FREQ     = DEF_CLKOUT2_FREQ,
  parameter longint unsigned CLKOUT3_FREQ     = DEF_CLKOUT3_FREQ,
  parameter longint unsigned CLKOUT4_FREQ     = DEF_CLKOUT4_FREQ,
  parameter                  FPGA_FAMILY      = "ZYNQ7000",
  parameter int unsigned     LOCK_CYCLES      = DEF_LOCK_CYCLES,
  parameter int unsigned     ACC_W            = DEF_ACC_W
) (
  input  logic OSC_IN,
  input  logic RST,
  output logic OSC_OUT,
  output logic SYS_CLK_OUT,
  output logic CLKOUT1,
  output logic CLKOUT2,
  output logic CLKOUT3,
  output logic CLKOUT4,
`ifdef CLKMGR_SQUARE_OUT_EN
  output logic SYS_CLK_SQ,
  output logic CLKOUT1_SQ,
  output logic CLKOUT2_SQ,
  output logic CLKOUT3_SQ,
  output logic CLKOUT4_SQ,
`endif
  output logic SYS_CLK_LOCKED
);

  // The family name is kept only for drop-in compatibility; both arms are identical.
  localparam int unsigned LOCK_TGT = (FPGA_FAMILY != '0) ? LOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned CNT_W    = $clog2(LOCK_TGT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TGT);

  localparam logic [NUM_CH-1:0][63:0] FREQ_TBL =
    {CLKOUT4_FREQ, CLKOUT3_FREQ, CLKOUT2_FREQ, CLKOUT1_FREQ, SYSCLK_FREQ};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic [NUM_CH-1:0] stb;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    locked_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge OSC_IN) begin
    if (RST) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

`ifdef CLKMGR_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq;
`endif

  // Channels step on the locking edge itself so a saturated strobe is high in the first locked cycle.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_mgr_a_nco #(
      .ACC_W (ACC_W),
      .INC   (calc_inc(FREQ_TBL[i], INPUT_CLOCK_FREQ, ACC_W)),
      .SAT   (calc_sat(FREQ_TBL[i], INPUT_CLOCK_FREQ))
    ) u_nco (
      .clk    (OSC_IN),
      .rst    (RST),
      .run    (locked_d),
      .strobe (stb[i])
`ifdef CLKMGR_SQUARE_OUT_EN
      ,
      .sq     (sq[i])
`endif
    );
  end

  assign OSC_OUT        = OSC_IN;
  assign SYS_CLK_LOCKED = locked_q;
  assign {CLKOUT4, CLKOUT3, CLKOUT2, CLKOUT1, SYS_CLK_OUT} = stb;

`ifdef CLKMGR_SQUARE_OUT_EN
  assign {CLKOUT4_SQ, CLKOUT3_SQ, CLKOUT2_SQ, CLKOUT1_SQ, SYS_CLK_SQ} = sq;
`endif

endmodule

// File: tb/tb_clk_mgr_a.sv
// Directed bench for clk_mgr_a with default parameters: reset, lock timing, channel rates,
// saturation and mid-run reset; square outputs are checked when CLKMGR_SQUARE_OUT_EN is defined.
module tb_clk_mgr_a;

  logic OSC_IN = 1'b0;
  logic RST    = 1'b1;
  logic OSC_OUT, SYS_CLK_OUT, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4, SYS_CLK_LOCKED;
`ifdef CLKMGR_SQUARE_OUT_EN
  logic SYS_CLK_SQ, CLKOUT1_SQ, CLKOUT2_SQ, CLKOUT3_SQ, CLKOUT4_SQ;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 OSC_IN = ~OSC_IN;

  clk_mgr_a dut (
    .OSC_IN         (OSC_IN),
    .RST            (RST),
    .OSC_OUT        (OSC_OUT),
    .SYS_CLK_OUT    (SYS_CLK_OUT),
    .CLKOUT1        (CLKOUT1),
    .CLKOUT2        (CLKOUT2),
    .CLKOUT3        (CLKOUT3),
    .CLKOUT4        (CLKOUT4),
`ifdef CLKMGR_SQUARE_OUT_EN
    .SYS_CLK_SQ     (SYS_CLK_SQ),
    .CLKOUT1_SQ     (CLKOUT1_SQ),
    .CLKOUT2_SQ     (CLKOUT2_SQ),
    .CLKOUT3_SQ     (CLKOUT3_SQ),
    .CLKOUT4_SQ     (CLKOUT4_SQ),
`endif
    .SYS_CLK_LOCKED (SYS_CLK_LOCKED)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge OSC_IN);
    @(negedge OSC_IN);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lock"}, 64'(SYS_CLK_LOCKED), 64'd0);
    chk({tag, "_stb"}, 64'({SYS_CLK_OUT, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4}), 64'd0);
`ifdef CLKMGR_SQUARE_OUT_EN
    chk({tag, "_sq"}, 64'({SYS_CLK_SQ, CLKOUT1_SQ, CLKOUT2_SQ, CLKOUT3_SQ, CLKOUT4_SQ}), 64'd0);
`endif
  endtask

  initial begin
    int sys_cnt;
    int ck2_cnt;
    int last;
    int max_gap;

    // Reset held for three edges.
    RST = 1'b1;
    repeat (3) @(posedge OSC_IN);
    @(negedge OSC_IN);
    chk_idle("rst");
    chk("osc_lo", 64'(OSC_OUT), 64'd0);
    @(posedge OSC_IN);
    #1 chk("osc_hi", 64'(OSC_OUT), 64'd1);
    @(negedge OSC_IN);

    // Fifteen settle edges: still unlocked, everything quiet.
    RST = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk_idle($sformatf("pre%0d", k));
    end

    // Locked cycle c follows the (15+c)-th edge after release.
    sys_cnt = 0;
    ck2_cnt = 0;
    last    = 0;
    max_gap = 0;
    for (int c = 1; c <= 136; c++) begin
      step();
      chk($sformatf("lock_c%0d", c), 64'(SYS_CLK_LOCKED), 64'd1);
      chk($sformatf("ck1_c%0d", c), 64'(CLKOUT1), 64'(c % 2 == 0));
      chk($sformatf("ck2_c%0d", c), 64'(CLKOUT2), 64'(c % 4 == 0));
      chk($sformatf("ck3_c%0d", c), 64'(CLKOUT3), 64'd1);
      chk($sformatf("ck4_c%0d", c), 64'(CLKOUT4), 64'd1);
      if (c <= 100) begin
        if (CLKOUT2 === 1'b1) ck2_cnt++;
        if (SYS_CLK_OUT === 1'b1) begin
          sys_cnt++;
          if (c - last > max_gap) max_gap = c - last;
          last = c;
        end
`ifdef CLKMGR_SQUARE_OUT_EN
        chk($sformatf("sq2_c%0d", c), 64'(CLKOUT2_SQ), 64'((c / 2) % 2 == 1));
        chk($sformatf("sq4_c%0d", c), 64'(CLKOUT4_SQ), 64'(c >= 2 && c % 2 == 0));
`endif
      end
    end
    chk("sys_cnt100", 64'(sys_cnt), 64'd80);
    chk("ck2_cnt100", 64'(ck2_cnt), 64'd25);
    chk("sys_gap_le2", 64'(max_gap <= 2), 64'd1);

    // One-edge reset mid-run, then relock and phase restart.
    RST = 1'b1;
    step();
    chk_idle("midrst");
    RST = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk_idle($sformatf("re_pre%0d", k));
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("re_lock_c%0d", c), 64'(SYS_CLK_LOCKED), 64'd1);
      chk($sformatf("re_ck1_c%0d", c), 64'(CLKOUT1), 64'(c % 2 == 0));
      chk($sformatf("re_ck2_c%0d", c), 64'(CLKOUT2), 64'(c % 4 == 0));
      chk($sformatf("re_ck34_c%0d", c), 64'({CLKOUT3, CLKOUT4}), 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
